// File: rtl/cmplx_alu_pkg.sv
// cmplx_alu_pkg: shared op/state enums and sizing helpers for the complex ALU.
package cmplx_alu_pkg;
  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_CMUL} op_e;
  typedef enum logic [2:0] {IDLE, M1, M2, M3, DONE} state_e;
  localparam int MAG_W_DEF = 4;
  function automatic int res_w(input int mag_w);
    return 2 * mag_w + 2;
  endfunction
endpackage

// File: rtl/cmplx_alu_seq_sm_addsub.sv
// sm_addsub: combinational sign-magnitude add/subtract with normalised (never negative) zero.
module sm_addsub #(
  parameter int W = 10
) (
  input  logic [W:0] x,
  input  logic [W:0] y,
  input  logic       sub,
  output logic [W:0] z
);
  logic ys, same, xge;
  logic [W-1:0] m;
  always_comb begin
    ys = y[W] ^ sub;
    same = x[W] == ys;
    xge = x[W-1:0] >= y[W-1:0];
    m = same ? x[W-1:0] + y[W-1:0] : xge ? x[W-1:0] - y[W-1:0] : y[W-1:0] - x[W-1:0];
    z = {(m != '0) & ((same || xge) ? x[W] : ys), m};
  end
endmodule

// File: rtl/cmplx_alu_seq.sv
// cmplx_alu_seq: handshaked sign-magnitude complex ALU, 3-multiply schedule on one multiplier.
// Defining CMPLX_ALU_ZFLAG_EN adds the registered out_zero flag.
module cmplx_alu_seq
  import cmplx_alu_pkg::*;
#(
  parameter int MAG_W = MAG_W_DEF,
  parameter int RES_W = res_w(MAG_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [MAG_W:0]   a_re,
  input  logic [MAG_W:0]   a_im,
  input  logic [MAG_W:0]   b_re,
  input  logic [MAG_W:0]   b_im,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RES_W:0]   res_re,
  output logic [RES_W:0]   res_im
`ifdef CMPLX_ALU_ZFLAG_EN
  ,
  output logic             out_zero
`endif
);
  state_e st, nxt;
  logic [MAG_W:0] a, b, c, d, mul_x;
  logic [RES_W:0] k1, k2, prod, pre_x, pre_y, pre_z, re_x, re_y, re_z, im_x, im_y, im_z;
  logic [RES_W-1:0] prod_m;
  logic pre_sub, re_sub, im_sub, accept, wr;
  function automatic logic [MAG_W:0] nz(input logic [MAG_W:0] v);
    return {v[MAG_W] & |v[MAG_W-1:0], v[MAG_W-1:0]};
  endfunction
  function automatic logic [RES_W:0] ext(input logic [MAG_W:0] v);
    return {v[MAG_W] & |v[MAG_W-1:0], {(RES_W-MAG_W){1'b0}}, v[MAG_W-1:0]};
  endfunction
  assign in_ready = st == IDLE;
  assign out_valid = st == DONE;
  assign accept = in_valid && st == IDLE;
  assign wr = (accept && !op[1]) || st == M3;
  // M1: c*(a+b), M2: a*(d-c), M3: b*(c+d); the pre-adder feeds the shared multiplier
  always_comb begin
    nxt = st == IDLE ? (in_valid ? (op[1] ? M1 : DONE) : IDLE) :
          st == M1 ? M2 : st == M2 ? M3 : st == M3 ? DONE :
          (st == DONE && !out_ready) ? DONE : IDLE;
    pre_x = st == M1 ? ext(a) : st == M2 ? ext(d) : ext(c);
    pre_y = st == M1 ? ext(b) : st == M2 ? ext(c) : ext(d);
    pre_sub = st == M2;
    mul_x = st == M1 ? c : st == M2 ? a : b;
    re_x = st == M3 ? k1 : ext(a_re);
    re_y = st == M3 ? prod : ext(b_re);
    re_sub = st == M3 || op == OP_SUB;
    im_x = st == M3 ? k1 : ext(a_im);
    im_y = st == M3 ? k2 : ext(b_im);
    im_sub = st != M3 && op == OP_SUB;
  end
  assign prod_m = {{(RES_W-MAG_W){1'b0}}, mul_x[MAG_W-1:0]} * pre_z[RES_W-1:0];
  assign prod = {(mul_x[MAG_W] ^ pre_z[RES_W]) & |prod_m, prod_m};
  sm_addsub #(.W(RES_W)) u_pre (.x(pre_x), .y(pre_y), .sub(pre_sub), .z(pre_z));
  sm_addsub #(.W(RES_W)) u_re  (.x(re_x),  .y(re_y),  .sub(re_sub),  .z(re_z));
  sm_addsub #(.W(RES_W)) u_im  (.x(im_x),  .y(im_y),  .sub(im_sub),  .z(im_z));
  always_ff @(posedge clk) st <= rst ? IDLE : nxt;
  // conjugation folds into the captured sign of d
  always_ff @(posedge clk) begin
    if (accept) begin
      a <= nz(a_re);
      b <= nz(a_im);
      c <= nz(b_re);
      d <= {(b_im[MAG_W] ^ (op == OP_CMUL)) & |b_im[MAG_W-1:0], b_im[MAG_W-1:0]};
    end
    if (st == M1) k1 <= prod;
    if (st == M2) k2 <= prod;
  end
  always_ff @(posedge clk)
    if (rst) begin
      res_re <= '0;
      res_im <= '0;
    end else if (wr) begin
      res_re <= re_z;
      res_im <= im_z;
    end
`ifdef CMPLX_ALU_ZFLAG_EN
  always_ff @(posedge clk)
    if (rst) out_zero <= 1'b0;
    else if (wr) out_zero <= re_z[RES_W-1:0] == '0 && im_z[RES_W-1:0] == '0;
`endif
endmodule
